// File: rtl/seg_scan.sv
// Four-digit multiplexed 7-segment scanner (MM:SS) with frame-shadowed digits
// and blink blanking of one digit pair while in adjust mode.
module seg_scan #(
   parameter int NUM_DIGITS  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    refresh_in,
   input  logic                    blink_in,
   input  logic                    adj,
   input  logic                    sel,
   input  logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp
);

   localparam int IDX_W = $clog2(NUM_DIGITS);

   logic [SYNC_STAGES-1:0]  r_sync_q, r_sync_d;
   logic                    r_d_q, r_d_d;
   logic [SYNC_STAGES-1:0]  b_sync_q, b_sync_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;

   logic       r_s;
   logic       b_s;
   logic       scan_tick;
   logic       in_pair;
   logic       blank;
   logic [3:0] nibble;

   function automatic logic [6:0] decode(input logic [3:0] bcd);
      case (bcd)
         4'd0:    decode = 7'b1000000;
         4'd1:    decode = 7'b1111001;
         4'd2:    decode = 7'b0100100;
         4'd3:    decode = 7'b0110000;
         4'd4:    decode = 7'b0011001;
         4'd5:    decode = 7'b0010010;
         4'd6:    decode = 7'b0000010;
         4'd7:    decode = 7'b1111000;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0010000;
         default: decode = 7'b0111111;
      endcase
   endfunction

   assign r_s       = r_sync_q[SYNC_STAGES-1];
   assign b_s       = b_sync_q[SYNC_STAGES-1];
   assign scan_tick = r_s & ~r_d_q;

   // sel=0 blanks the minutes (upper idx half), sel=1 the seconds (lower half).
   assign in_pair = idx_q[IDX_W-1] ^ sel;
   assign blank   = adj & b_s & in_pair;
   assign nibble  = shadow_q[{idx_q, 2'b00} +: 4];

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
      r_sync_d = {r_sync_q[SYNC_STAGES-2:0], refresh_in};
      r_d_d    = r_s;
      b_sync_d = {b_sync_q[SYNC_STAGES-2:0], blink_in};
      idx_d    = idx_q;
      shadow_d = shadow_q;

      if (scan_tick) begin
         idx_d = idx_q + 1'b1;
         // Whole frame is captured at the wrap so a frame never mixes two samples.
         if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            shadow_d = digits;
         end
      end

      an_d  = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
      seg_d = decode(nibble);
      dp_d  = !((idx_q == IDX_W'(2)) && !blank);
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (!rst) begin
         r_sync_q <= '0;
         r_d_q    <= 1'b0;
         b_sync_q <= '0;
         idx_q    <= '0;
         // NOTE: the shadow is a plain register, not a memory, and must reset so the display starts at 0000.
         shadow_q <= '0;
         an_q     <= '1;
         seg_q    <= 7'b1111111;
         dp_q     <= 1'b1;
      end else begin
         r_sync_q <= r_sync_d;
         r_d_q    <= r_d_d;
         b_sync_q <= b_sync_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: reset, scan order, frame shadow, blink,
// invalid BCD, long refresh pulse and mid-scan reset.
module tb_seg_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic        refresh_in;
   logic        blink_in;
   logic        adj;
   logic        sel;
   logic [15:0] digits;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [6:0] S0    = 7'b1000000;
   localparam logic [6:0] S1    = 7'b1111001;
   localparam logic [6:0] S2    = 7'b0100100;
   localparam logic [6:0] S3    = 7'b0110000;
   localparam logic [6:0] S5    = 7'b0010010;
   localparam logic [6:0] S9    = 7'b0010000;
   localparam logic [6:0] SDASH = 7'b0111111;
   localparam logic [6:0] SOFF  = 7'b1111111;

   seg_scan #(.NUM_DIGITS(4), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .refresh_in (refresh_in),
      .blink_in   (blink_in),
      .adj        (adj),
      .sel        (sel),
      .digits     (digits),
      .an         (an),
      .seg        (seg),
      .dp         (dp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_disp(input string tag, input logic [3:0] e_an,
                             input logic [6:0] e_seg, input logic e_dp);
      check({tag, ".an"},  {12'h0, an},  {12'h0, e_an});
      check({tag, ".seg"}, {9'h0, seg},  {9'h0, e_seg});
      check({tag, ".dp"},  {15'h0, dp},  {15'h0, e_dp});
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Rising refresh edge at a negedge; an must still hold old_an after 3 clk
   // edges and show the new digit after the 4th (caller checks that).
   task automatic pulse(input string tag, input logic [3:0] old_an);
      refresh_in = 1'b1;
      cycles(2);
      refresh_in = 1'b0;
      cycles(1);
      check({tag, ".hold3"}, {12'h0, an}, {12'h0, old_an});
      cycles(1);
   endtask

   initial begin
      rst        = 1'b0;
      refresh_in = 1'b1;
      blink_in   = 1'b0;
      adj        = 1'b0;
      sel        = 1'b0;
      digits     = 16'h1259;

      // Reset held with refresh_in high.
      cycles(3);
      check_disp("rst", 4'b1111, SOFF, 1'b1);

      rst = 1'b1;
      cycles(1);
      check_disp("rel1", 4'b1110, S0, 1'b1);
      cycles(2);
      check("rel3.an", {12'h0, an}, 16'h000E);
      cycles(1);
      check_disp("rel4", 4'b1101, S0, 1'b1);
      cycles(20);
      check("rel_hold.an", {12'h0, an}, 16'h000D);
      refresh_in = 1'b0;
      cycles(3);

      // Constant-low refresh: no movement.
      cycles(20);
      check("const.an", {12'h0, an}, 16'h000D);

      // First frame still shows zeros until the wrap loads 1259.
      pulse("p_i2", 4'b1101);
      check_disp("f0_i2", 4'b1011, S0, 1'b0);
      pulse("p_i3", 4'b1011);
      check_disp("f0_i3", 4'b0111, S0, 1'b1);
      pulse("p_w1", 4'b0111);
      check_disp("f1_i0", 4'b1110, S9, 1'b1);
      pulse("p_f1i1", 4'b1110);
      check_disp("f1_i1", 4'b1101, S5, 1'b1);

      // No tearing: mid-frame change is not seen until the next wrap.
      digits = 16'h1300;
      pulse("p_f1i2", 4'b1101);
      check_disp("f1_i2", 4'b1011, S2, 1'b0);
      pulse("p_f1i3", 4'b1011);
      check_disp("f1_i3", 4'b0111, S1, 1'b1);
      pulse("p_w2", 4'b0111);
      check_disp("f2_i0", 4'b1110, S0, 1'b1);
      pulse("p_f2i1", 4'b1110);
      check_disp("f2_i1", 4'b1101, S0, 1'b1);
      pulse("p_f2i2", 4'b1101);
      check_disp("f2_i2", 4'b1011, S3, 1'b0);
      pulse("p_f2i3", 4'b1011);
      check_disp("f2_i3", 4'b0111, S1, 1'b1);

      // Blink on minutes while at idx 3: blank lands 3 edges after blink_in.
      adj      = 1'b1;
      sel      = 1'b0;
      blink_in = 1'b1;
      cycles(2);
      check("bl2.an", {12'h0, an}, 16'h0007);
      cycles(1);
      check_disp("bl3", 4'b1111, S1, 1'b1);
      pulse("p_b0", 4'b1111);
      check_disp("b_i0", 4'b1110, S0, 1'b1);
      pulse("p_b1", 4'b1110);
      check_disp("b_i1", 4'b1101, S0, 1'b1);
      pulse("p_b2", 4'b1101);
      check_disp("b_i2", 4'b1111, S3, 1'b1);

      // Swap to seconds pair: 1 edge from sel to an.
      sel = 1'b1;
      cycles(1);
      check_disp("sel1", 4'b1011, S3, 1'b0);
      pulse("p_s3", 4'b1011);
      check_disp("s_i3", 4'b0111, S1, 1'b1);
      pulse("p_s0", 4'b0111);
      check_disp("s_i0", 4'b1111, S0, 1'b1);

      blink_in = 1'b0;
      cycles(2);
      check("unbl2.an", {12'h0, an}, 16'h000F);
      cycles(1);
      check("unbl3.an", {12'h0, an}, 16'h000E);
      adj = 1'b0;
      sel = 1'b0;

      // Invalid BCD: load A000 at the next wrap.
      digits = 16'hA000;
      pulse("p_v1", 4'b1110);
      pulse("p_v2", 4'b1101);
      pulse("p_v3", 4'b1011);
      pulse("p_v0", 4'b0111);
      check_disp("v_i0", 4'b1110, S0, 1'b1);
      pulse("p_v1b", 4'b1110);
      pulse("p_v2b", 4'b1101);
      check_disp("v_i2", 4'b1011, S0, 1'b0);
      pulse("p_v3b", 4'b1011);
      check_disp("v_i3", 4'b0111, SDASH, 1'b1);

      // Long high pulse: exactly one advance (3 -> 0).
      refresh_in = 1'b1;
      cycles(1000);
      check_disp("long", 4'b1110, S0, 1'b1);
      refresh_in = 1'b0;
      cycles(10);
      check("long_after.an", {12'h0, an}, 16'h000E);

      // Reset mid-scan at idx 1.
      pulse("p_m1", 4'b1110);
      check("mid.an", {12'h0, an}, 16'h000D);
      rst = 1'b0;
      cycles(1);
      check_disp("mid_rst", 4'b1111, SOFF, 1'b1);
      rst = 1'b1;
      cycles(1);
      check_disp("mid_rel", 4'b1110, S0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
